// File: rtl/noc_pkg.sv
// Shared definitions for the NoC local-port injection path.
//   NOC_FLIT_W    default flit width (matches router data_in)
//   NOC_LEN_W     default payload length field width
//   sched_state_t injection scheduler FSM states
package noc_pkg;

    localparam int NOC_FLIT_W = 16;
    localparam int NOC_LEN_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SIZE,
        PAYLOAD,
        DONE
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after ptr_i, wrapping.
//   req_i  in   N       request vector
//   ptr_i  in   IDX_W   highest-priority index this round
//   gnt_o  out  N       one-hot grant (all zero when req_i == 0)
//   idx_o  out  IDX_W   index of the granted requester (0 when req_i == 0)
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found;
    int   cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            // ptr_i < N and i < N, so one conditional subtract is a full modulo
            cand = int'(ptr_i) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/noc_inject_scheduler.sv
// Packet injection scheduler for the router local port. N_REQ local requesters share one router
// input; they are served round-robin, one whole packet at a time, serialised as
// header (dest) flit, size (length) flit, then the payload flits.
//   clock     in   1             router clock
//   reset     in   1             asynchronous active-high reset
//   req_i     in   N_REQ         packet pending per requester (held until done_o)
//   dest_i    in   N_REQ*FLIT_W  per-requester header flit
//   len_i     in   N_REQ*LEN_W   per-requester payload flit count
//   pdata_i   in   N_REQ*FLIT_W  per-requester payload flit
//   pvalid_i  in   N_REQ         payload flit valid
//   pready_o  out  N_REQ         payload flit accepted (with pvalid_i)
//   grant_o   out  N_REQ         one-hot current owner of the router port
//   done_o    out  N_REQ         one-cycle pulse after the last flit of a packet
//   tx        out  1             flit valid toward router rx
//   data_o    out  FLIT_W        flit toward router data_in (0 when tx is low)
//   credit_i  in   1             router credit; a flit transfers on tx & credit_i
module noc_inject_scheduler
    import noc_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int FLIT_W = NOC_FLIT_W,
    parameter int LEN_W  = NOC_LEN_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*FLIT_W-1:0] dest_i,
    input  logic [N_REQ*LEN_W-1:0]  len_i,
    input  logic [N_REQ*FLIT_W-1:0] pdata_i,
    input  logic [N_REQ-1:0]        pvalid_i,
    output logic [N_REQ-1:0]        pready_o,
    output logic [N_REQ-1:0]        grant_o,
    output logic [N_REQ-1:0]        done_o,
    output logic                    tx,
    output logic [FLIT_W-1:0]       data_o,
    input  logic                    credit_i
);

    localparam int IDX_W = $clog2(N_REQ);

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] w_q, w_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;

    logic [FLIT_W-1:0] sel_dest;
    logic [LEN_W-1:0]  sel_len;
    logic [FLIT_W-1:0] sel_pdata;
    logic              sel_pvalid;
    logic              pay_xfer;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign sel_dest   = dest_i[w_q*FLIT_W +: FLIT_W];
    assign sel_len    = len_i[w_q*LEN_W +: LEN_W];
    assign sel_pdata  = pdata_i[w_q*FLIT_W +: FLIT_W];
    assign sel_pvalid = pvalid_i[w_q];
    assign pay_xfer   = sel_pvalid & credit_i;
    assign grant_o    = grant_q;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req_i) state_d = HDR;
            HDR:     if (credit_i) state_d = SIZE;
            SIZE:    if (credit_i) state_d = (cnt_q != '0) ? PAYLOAD : DONE;
            // cnt is compared against 1 before the decrement, so it never wraps
            PAYLOAD: if (pay_xfer && cnt_q == LEN_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Owner, grant, payload counter and round-robin pointer
    always_comb begin
        w_d      = w_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && |req_i) begin
            w_d     = arb_idx;
            grant_d = arb_gnt;
            cnt_d   = len_i[arb_idx*LEN_W +: LEN_W];
        end
        if (state_q == PAYLOAD && pay_xfer) begin
            cnt_d = cnt_q - LEN_W'(1);
        end
        if (state_q == DONE) begin
            grant_d  = '0;
            rr_ptr_d = (w_q == IDX_W'(N_REQ - 1)) ? '0 : w_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_q      <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            w_q      <= w_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Outputs
    always_comb begin
        tx       = 1'b0;
        data_o   = '0;
        pready_o = '0;
        done_o   = '0;
        unique case (state_q)
            HDR: begin
                tx     = 1'b1;
                data_o = sel_dest;
            end
            SIZE: begin
                tx                  = 1'b1;
                data_o[LEN_W-1:0]   = sel_len;
            end
            PAYLOAD: begin
                tx            = sel_pvalid;
                pready_o[w_q] = credit_i;
                if (sel_pvalid) begin
                    data_o = sel_pdata;
                end
            end
            DONE:    done_o[w_q] = 1'b1;
            default: ;
        endcase
    end

    // A requester must hold req_i until its packet has been fully sent
    a_req_held: assert property (@(posedge clock) disable iff (reset)
        (state_q == HDR || state_q == SIZE || state_q == PAYLOAD) |-> req_i[w_q]);

endmodule

// File: tb/tb_noc_inject_scheduler.sv
// Scoreboard bench for noc_inject_scheduler: stimulus pushes the expected flit stream and done
// pulses; a negedge monitor pops and compares whenever a flit transfers or done_o pulses.
module tb_noc_inject_scheduler;

    localparam int N  = 4;
    localparam int FW = 16;
    localparam int LW = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_i = '0;
    logic [N*FW-1:0] dest_i = '0;
    logic [N*LW-1:0] len_i = '0;
    logic [N*FW-1:0] pdata_i = '0;
    logic [N-1:0]    pvalid_i = '0;
    logic [N-1:0]    pready_o;
    logic [N-1:0]    grant_o;
    logic [N-1:0]    done_o;
    logic            tx;
    logic [FW-1:0]   data_o;
    logic            credit_i = 1'b1;

    noc_inject_scheduler #(
        .N_REQ  (N),
        .FLIT_W (FW),
        .LEN_W  (LW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_i    (req_i),
        .dest_i   (dest_i),
        .len_i    (len_i),
        .pdata_i  (pdata_i),
        .pvalid_i (pvalid_i),
        .pready_o (pready_o),
        .grant_o  (grant_o),
        .done_o   (done_o),
        .tx       (tx),
        .data_o   (data_o),
        .credit_i (credit_i)
    );

    always #5 clock = ~clock;

    typedef struct { int r; logic [15:0] d; } exp_t;
    typedef struct { int gap; logic [15:0] d; } pitem_t;

    exp_t        exp_q[$];
    int          done_q[$];
    pitem_t      pq[N][$];
    int          pkts_left[N];
    int          gap_left[N];
    logic [15:0] dest_v[N];
    logic [15:0] len_v[N];
    logic        fired[N];
    int          pctr = 0;
    int          cyc = 0;
    int          xfer_log[$];
    int          pready_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    always @(posedge clock) cyc++;

    // Requester model: presents queued payload flits, inserting the programmed gaps
    initial begin
        for (int r = 0; r < N; r++) begin
            pkts_left[r] = 0; gap_left[r] = 0; dest_v[r] = '0; len_v[r] = '0; fired[r] = 1'b0;
        end
        forever begin
            @(negedge clock);
            for (int r = 0; r < N; r++) begin
                fired[r] = pvalid_i[r] & pready_o[r];
                if (done_o[r] && pkts_left[r] > 0) pkts_left[r]--;
            end
            @(posedge clock);
            #1;
            for (int r = 0; r < N; r++) begin
                if (fired[r] && pq[r].size() > 0) begin
                    pq[r].delete(0);
                    if (pq[r].size() > 0) gap_left[r] = pq[r][0].gap;
                end
                req_i[r]           = pkts_left[r] > 0;
                dest_i[r*FW +: FW] = dest_v[r];
                len_i[r*LW +: LW]  = len_v[r];
                if (pq[r].size() > 0 && gap_left[r] == 0) begin
                    pvalid_i[r]         = 1'b1;
                    pdata_i[r*FW +: FW] = pq[r][0].d;
                end else begin
                    pvalid_i[r]         = 1'b0;
                    pdata_i[r*FW +: FW] = '0;
                    if (pq[r].size() > 0) gap_left[r]--;
                end
            end
        end
    end

    // Monitor
    exp_t e;
    int   dr;
    always @(negedge clock) begin
        if (!reset) begin
            if (tx && credit_i) begin
                xfer_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_flit", 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("flit_data", 32'(data_o), 32'(e.d));
                    chk("flit_owner", 32'(grant_o), 32'(1) << e.r);
                end
            end
            if (!tx) chk("idle_data_zero", 32'(data_o), 32'h0);
            chk("pready_owner", 32'(pready_o & ~grant_o), 32'h0);
            if (pready_o != '0) pready_cnt++;
            if (done_o != '0) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(done_o), 32'h0);
                end else begin
                    dr = done_q.pop_front();
                    chk("done_onehot", 32'(done_o), 32'(1) << dr);
                end
            end
        end
    end

    task automatic queue_pkt(input int r, input logic [15:0] dest, input int len,
                             input bit gapped);
        exp_t   x;
        pitem_t p;
        dest_v[r] = dest;
        len_v[r]  = 16'(len);
        x.r = r;
        x.d = dest;
        exp_q.push_back(x);
        x.d = 16'(len);
        exp_q.push_back(x);
        for (int i = 0; i < len; i++) begin
            p.gap = (gapped && i > 0) ? (i % 3) + 1 : 0;
            p.d   = 16'hC000 + 16'(pctr);
            pctr++;
            pq[r].push_back(p);
            x.d = p.d;
            exp_q.push_back(x);
        end
        done_q.push_back(r);
        pkts_left[r]++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            @(posedge clock);
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size() + done_q.size()), 32'h0);
        repeat (3) @(posedge clock);
        #2;
        chk("grant_idle", 32'(grant_o), 32'h0);
    endtask

    task automatic flush();
        exp_q.delete();
        done_q.delete();
        for (int r = 0; r < N; r++) begin
            pq[r].delete();
            pkts_left[r] = 0;
        end
    endtask

    // Reset pulse starting 3 time units after a clock edge; outputs must clear at once
    task automatic do_reset();
        @(posedge clock);
        #3;
        reset = 1'b1;
        flush();
        #1;
        chk("rst_tx", 32'(tx), 32'h0);
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_data", 32'(data_o), 32'h0);
        chk("rst_pready", 32'(pready_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        repeat (2) @(posedge clock);
        #4;
        reset = 1'b0;
        @(posedge clock);
        #2;
    endtask

    function automatic int span(input int base, input int n);
        if (xfer_log.size() < base + n) return -1;
        return xfer_log[base+n-1] - xfer_log[base];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int pr;

        do_reset();

        // 1: single packet, back-to-back flits, one-cycle grant latency
        base = xfer_log.size();
        queue_pkt(0, 16'h0102, 3, 1'b0);
        n = 0;
        while (!req_i[0] && n < 10) begin @(negedge clock); n++; end
        chk("t1_no_grant_yet", 32'(grant_o), 32'h0);
        @(negedge clock);
        chk("t1_grant", 32'(grant_o), 32'h1);
        chk("t1_hdr_tx", 32'(tx), 32'h1);
        chk("t1_hdr_data", 32'(data_o), 32'h0102);
        drain(100);
        chk("t1_xfers", 32'(xfer_log.size() - base), 32'd5);
        chk("t1_span", 32'(span(base, 5)), 32'd4);

        // 2: all four requesting, len=1; order 0,1,2,3,0
        do_reset();
        base = xfer_log.size();
        queue_pkt(0, 16'h2000, 1, 1'b0);
        queue_pkt(1, 16'h2001, 1, 1'b0);
        queue_pkt(2, 16'h2002, 1, 1'b0);
        queue_pkt(3, 16'h2003, 1, 1'b0);
        queue_pkt(0, 16'h2000, 1, 1'b0);
        drain(200);
        chk("t2_xfers", 32'(xfer_log.size() - base), 32'd15);

        // 3: zero-length packet on requester 2
        base = xfer_log.size();
        pr   = pready_cnt;
        queue_pkt(2, 16'h0302, 0, 1'b0);
        drain(100);
        chk("t3_xfers", 32'(xfer_log.size() - base), 32'd2);
        chk("t3_pready_quiet", 32'(pready_cnt - pr), 32'd0);

        // 4: credit stall in SIZE, then toggling credit through payload
        base = xfer_log.size();
        queue_pkt(1, 16'h0B0B, 4, 1'b0);
        n = 0;
        while (!(tx && credit_i && data_o == 16'h0B0B) && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("t4_hdr_seen", 32'(n < 50), 32'h1);
        @(posedge clock);
        #2;
        credit_i = 1'b0;
        repeat (10) begin
            @(negedge clock);
            chk("t4_stall_tx", 32'(tx), 32'h1);
            chk("t4_stall_data", 32'(data_o), 32'h0004);
        end
        @(posedge clock);
        #2;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            credit_i = (k % 2 == 0);
            @(posedge clock);
            #2;
        end
        credit_i = 1'b1;
        drain(100);
        chk("t4_xfers", 32'(xfer_log.size() - base), 32'd6);

        // 5: pvalid gaps of 2, 3 and 1 cycles between payload flits
        base = xfer_log.size();
        queue_pkt(3, 16'h0503, 4, 1'b1);
        drain(100);
        chk("t5_xfers", 32'(xfer_log.size() - base), 32'd6);
        chk("t5_span", 32'(span(base, 6)), 32'd11);

        // 6: move rr_ptr to 3, abort a packet with reset, then check pointer restarts at 0
        queue_pkt(2, 16'h0602, 0, 1'b0);
        drain(100);
        base = xfer_log.size();
        queue_pkt(0, 16'h0600, 5, 1'b0);
        n = 0;
        while (xfer_log.size() < base + 3 && n < 50) begin @(negedge clock); n++; end
        chk("t6_mid_payload", 32'(tx), 32'h1);
        do_reset();
        base = xfer_log.size();
        queue_pkt(0, 16'h0610, 1, 1'b0);
        queue_pkt(3, 16'h0613, 1, 1'b0);
        drain(100);
        chk("t6_xfers", 32'(xfer_log.size() - base), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
